// File: rtl/out_display_pkg.sv
// Shared constants for the output display: digit count, active-low segment codes
// and the conversion FSM states.
package ben_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
    seg_of_digit = (d > 4'd9) ? SEG_BLANK : SEG_DIGIT[d];
  endfunction

  // Two's-complement magnitude; 8'h80 wraps back to 8'h80, which read unsigned
  // is exactly 128, so eight bits always hold the full magnitude range.
  function automatic logic [7:0] magnitude(input logic [7:0] v, input logic neg);
    magnitude = neg ? (~v + 8'd1) : v;
  endfunction

endpackage

// File: rtl/out_display_if.sv
// CPU output-port side of the display: value/mode/strobe in, busy and the
// multiplexed segment/anode drive out.
interface out_display_if;
  import ben_pkg::*;

  logic [7:0]            i_value;
  logic                  i_load;
  logic                  i_signed;
  logic                  o_busy;
  logic [6:0]            o_seg;
  logic [NUM_DIGITS-1:0] o_an;

  modport master (
    output i_value, i_load, i_signed,
    input  o_busy, o_seg, o_an
  );

  modport slave (
    input  i_value, i_load, i_signed,
    output o_busy, o_seg, o_an
  );

endinterface

// File: rtl/out_display_bin2bcd.sv
// Sequential double-dabble: 8 binary bits to 10 BCD bits, one step per cycle.
// i_start loads the operand; o_done marks the cycle of the eighth step.
module bin2bcd_seq (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_bin,
  output logic       o_busy,
  output logic       o_done,
  output logic [9:0] o_bcd
);

  logic [17:0] r_sr;
  logic [2:0]  r_cnt;
  logic        r_busy;
  logic [3:0]  w_ones;
  logic [3:0]  w_tens;
  logic [17:0] w_sr_nxt;

  // Hundreds never exceeds 2 for an 8-bit input, so only ones/tens need the +3.
  always_comb begin
    w_ones   = (r_sr[11:8]  >= 4'd5) ? (r_sr[11:8]  + 4'd3) : r_sr[11:8];
    w_tens   = (r_sr[15:12] >= 4'd5) ? (r_sr[15:12] + 4'd3) : r_sr[15:12];
    w_sr_nxt = {r_sr[16], w_tens, w_ones, r_sr[7:0], 1'b0};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_sr   <= {10'd0, i_bin};
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_sr  <= w_sr_nxt;
      r_cnt <= r_cnt + 3'd1;
      if (r_cnt == 3'd7) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == 3'd7);
  assign o_bcd  = r_sr[17:8];

endmodule

// File: rtl/out_display.sv
// Captures CPU output-port writes, converts them to decimal and scans them onto a
// 4-digit common-anode display; loads arriving mid-conversion queue in a 1-deep slot.
module out_display
  import ben_pkg::*;
#(
  parameter int CLKS_PER_DIGIT = 50000
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  out_display_if.slave  bus
);

  localparam int             PW       = $clog2(CLKS_PER_DIGIT);
  localparam logic [PW-1:0]  PRE_LAST = PW'(CLKS_PER_DIGIT - 1);

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_pend_vld;
  logic        r_pend_sgn;
  logic [7:0]  r_pend_val;

  logic        w_start;
  logic        w_take_in;
  logic        w_commit;
  logic [7:0]  w_src_val;
  logic        w_src_sgn;
  logic        w_src_neg;
  logic        r_conv_neg;

  logic        w_eng_busy;
  logic        w_eng_done;
  logic [9:0]  w_eng_bcd;

  logic [3:0]  r_ones, r_tens, w_ones_nxt, w_tens_nxt;
  logic [1:0]  r_hund, w_hund_nxt;
  logic        r_neg, w_neg_nxt;

  logic [PW-1:0]         r_pre;
  logic                  w_pre_last;
  logic [1:0]            r_idx, w_idx_nxt;
  logic [6:0]            r_seg, w_seg_nxt;
  logic [NUM_DIGITS-1:0] r_an, w_an_nxt;
  logic                  r_busy;

  bin2bcd_seq u_bcd (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (w_start),
    .i_bin   (magnitude(w_src_val, w_src_neg)),
    .o_busy  (w_eng_busy),
    .o_done  (w_eng_done),
    .o_bcd   (w_eng_bcd)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (r_pend_vld || bus.i_load) w_state_nxt = ST_CONV;
      ST_CONV:   if (w_eng_done)               w_state_nxt = ST_COMMIT;
      ST_COMMIT: w_state_nxt = (r_pend_vld || bus.i_load) ? ST_CONV : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // In COMMIT a coincident load is newer than the slot, so it wins outright.
  always_comb begin
    w_start   = 1'b0;
    w_take_in = 1'b0;
    w_commit  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_start   = (r_pend_vld || bus.i_load) && !w_eng_busy;
        w_take_in = !r_pend_vld;
      end
      ST_COMMIT: begin
        w_commit  = 1'b1;
        w_start   = (r_pend_vld || bus.i_load) && !w_eng_busy;
        w_take_in = bus.i_load;
      end
      default: ;
    endcase
    w_src_val = w_take_in ? bus.i_value  : r_pend_val;
    w_src_sgn = w_take_in ? bus.i_signed : r_pend_sgn;
    w_src_neg = w_src_sgn && w_src_val[7];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_vld <= 1'b0;
      r_pend_val <= '0;
      r_pend_sgn <= 1'b0;
      r_conv_neg <= 1'b0;
    end else begin
      if (bus.i_load && !(w_start && w_take_in)) begin
        r_pend_vld <= 1'b1;
        r_pend_val <= bus.i_value;
        r_pend_sgn <= bus.i_signed;
      end else if (w_start) begin
        r_pend_vld <= 1'b0;
      end
      if (w_start) begin
        r_conv_neg <= w_src_neg;
      end
    end
  end

  always_comb begin
    w_ones_nxt = w_commit ? w_eng_bcd[3:0] : r_ones;
    w_tens_nxt = w_commit ? w_eng_bcd[7:4] : r_tens;
    w_hund_nxt = w_commit ? w_eng_bcd[9:8] : r_hund;
    w_neg_nxt  = w_commit ? r_conv_neg     : r_neg;
  end

  always_comb begin
    w_pre_last = (r_pre == PRE_LAST);
    w_idx_nxt  = w_pre_last ? (r_idx + 2'd1) : r_idx;
    w_an_nxt   = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << w_idx_nxt);
    case (w_idx_nxt)
      2'd0: w_seg_nxt = seg_of_digit(w_ones_nxt);
      2'd1: w_seg_nxt = (w_hund_nxt == 2'd0 && w_tens_nxt == 4'd0) ?
                        SEG_BLANK : seg_of_digit(w_tens_nxt);
      2'd2: w_seg_nxt = (w_hund_nxt == 2'd0) ? SEG_BLANK : seg_of_digit({2'b00, w_hund_nxt});
      default: w_seg_nxt = w_neg_nxt ? SEG_MINUS : SEG_BLANK;
    endcase
  end

  // Segments are driven from the next-state digits so a commit shows on the
  // very next cycle rather than one later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ones <= '0;
      r_tens <= '0;
      r_hund <= '0;
      r_neg  <= 1'b0;
      r_pre  <= '0;
      r_idx  <= '0;
      r_seg  <= SEG_BLANK;
      r_an   <= '1;
      r_busy <= 1'b0;
    end else begin
      r_ones <= w_ones_nxt;
      r_tens <= w_tens_nxt;
      r_hund <= w_hund_nxt;
      r_neg  <= w_neg_nxt;
      r_pre  <= w_pre_last ? '0 : (r_pre + 1'b1);
      r_idx  <= w_idx_nxt;
      r_seg  <= w_seg_nxt;
      r_an   <= w_an_nxt;
      r_busy <= (w_state_nxt != ST_IDLE);
    end
  end

  assign bus.o_seg  = r_seg;
  assign bus.o_an   = r_an;
  assign bus.o_busy = r_busy;

endmodule

// File: doc/out_display.md
Name: out_display

Overview:
- Receiving end of the CPU's 8-bit output port: captures each value written to the output register and shows it in decimal on a 4-digit, common-anode, multiplexed 7-segment display.
- Converts binary to BCD with a sequential double-dabble engine.
- Supports unsigned mode and two's-complement signed mode.
- Sits at the top level beside `cpu`, consuming `o_out` plus a load strobe.

Parameters:
- CLKS_PER_DIGIT, 50000, clock cycles each digit stays lit (must be ≥2; benches use 4).
- NUM_DIGITS, 4, number of display digits (fixed at 4; exposed for the package constant only).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_value  in  8  value from the CPU output register.
- i_load  in  1  single-cycle strobe: the output register was written this cycle.
- i_signed  in  1  display mode, sampled together with i_value on i_load (1 = two's complement).
- o_busy  out  1  conversion in progress.
- o_seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- o_an  out  4  digit enables, active-low; bit 0 is the rightmost digit.

Behaviour:
- Interface: one clock, i_clk. Reset i_rst_n is asynchronous, active-low. All outputs are registered.
- Reset values:
  - o_seg = 7'h7F, o_an = 4'hF, o_busy = 0.
  - Displayed digits = value 0, unsigned; pending slot empty; FSM in IDLE; prescaler and scan index = 0.
- FSM states: IDLE, CONV, COMMIT.
  - IDLE -> CONV: on i_load, or when the pending slot is full.
  - CONV: exactly 8 cycles, one double-dabble step per cycle (add 3 to every BCD nibble ≥5, then shift left 1). Uses an 18-bit shift register: 10 BCD bits + 8 binary bits.
  - CONV -> COMMIT after step 8.
  - COMMIT -> IDLE: writes the display digit registers, then returns to IDLE.
- Latency:
  - i_load at cycle L: o_busy = 1 in cycles L+1 through L+9.
  - New digits are visible on o_seg/o_an from cycle L+10 onward.
  - Display never shows partial results.
- Signed mode: if i_signed = 1 and i_value[7] = 1, the converted magnitude is (~v + 1); 8'h80 gives 128. The magnitude is computed into a 9-bit-safe value before BCD conversion.
- Load while busy:
  - Value and mode go to a one-deep pending slot.
  - A later load overwrites it (last wins).
  - After COMMIT the FSM goes directly to CONV with the pending value; o_busy stays 1 with no gap.
- Load coincident with COMMIT: treated as pending and processed next.
- Digit mapping (digit 0 = rightmost):
  - Digit 0: ones, always shown.
  - Digit 1: tens, blanked if hundreds = 0 and tens = 0.
  - Digit 2: hundreds, blanked if 0.
  - Digit 3: '-' if negative, else blank.
- Segment codes (active-low):
  - Digits 0–9: 40,79,24,30,19,12,02,78,00,10 (hex).
  - '-' = 7'h3F; blank = 7'h7F.
- Scan:
  - Prescaler counts 0..CLKS_PER_DIGIT-1.
  - On terminal count the scan index increments modulo 4: 0->1->2->3->0.
  - o_an = ~(1 << index) and the matching o_seg update in the same cycle.
  - The first enable is o_an = 4'hE, one cycle after reset release.
  - Scanning runs continuously, independent of conversion state.
- Reset mid-conversion: immediately returns to the reset state. The display shows "0", the pending value is lost, and no partial commit occurs.

Decomposition:
- Package ben_pkg holds:
  - NUM_DIGITS.
  - Segment constants SEG_DIGIT[0:9], SEG_MINUS, SEG_BLANK.
  - FSM state enum.
- One sub-module, bin2bcd_seq: the start/busy/done double-dabble engine, 8 input bits to 3 BCD nibbles.
- out_display keeps the pending slot, sign handling, blanking, prescaler and scan.

Test Plan:
- Reset release, no load, CLKS_PER_DIGIT = 4 -> o_an cycles E,D,B,7 every 4 clocks. o_seg = 40 on digit 0 and 7F on the others.
- i_load, value 255, unsigned -> o_busy high L+1..L+9. From L+10 the digits show 2,5,5 (24,12,12) with digit 3 blank.
- Signed 8'hFF, then 8'h80 -> display "-  1" (3F,7F,7F,79), then "-128" (3F,79,24,00).
- Three loads (7, 42, 100) at L, L+2, L+4 -> 7 is displayed, then 100. The value 42 never appears, and o_busy stays high continuously until 100 is committed.
- Load value 200, assert i_rst_n = 0 at L+5 -> outputs at reset values within the same cycle; after release the display shows "0".
